// File: rtl/ldc_issue_pkg.sv
// ---------------------------------------------------------------------------
// ldc_issue_pkg
// Shared defaults and types for the load-constant issue block.
//   LDC_DATA_W  : default constant width (C)
//   LDC_ADDR_W  : default register index width (R)
//   LDC_DEPTH   : default request FIFO depth (power of two, >= 2)
//   ldc_state_e : issue FSM state, 1-bit encoded
// ---------------------------------------------------------------------------
package ldc_issue_pkg;

    localparam int LDC_DATA_W = 20;
    localparam int LDC_ADDR_W = 6;
    localparam int LDC_DEPTH  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } ldc_state_e;

endpackage

// File: rtl/ldc_issue_if.sv
// ---------------------------------------------------------------------------
// ldc_issue_if
// Request and LDC-stage handshakes of the issue block.
//   req_valid/req_ready/req_const/req_reg : upstream load-constant requests
//   out_valid/out_ready/out_const/out_reg : C/R pair towards the LDC stage
// Modports:
//   master : the environment (drives requests, consumes C/R pairs)
//   slave  : the issue block
// ---------------------------------------------------------------------------
interface ldc_issue_if
    import ldc_issue_pkg::*;
#(
    parameter int DATA_W = LDC_DATA_W,
    parameter int ADDR_W = LDC_ADDR_W
) ();

    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_const;
    logic [ADDR_W-1:0] req_reg;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_const;
    logic [ADDR_W-1:0] out_reg;

    modport master (
        output req_valid, req_const, req_reg, out_ready,
        input  req_ready, out_valid, out_const, out_reg
    );

    modport slave (
        input  req_valid, req_const, req_reg, out_ready,
        output req_ready, out_valid, out_const, out_reg
    );

endinterface

// File: rtl/ldc_fifo.sv
// ---------------------------------------------------------------------------
// ldc_fifo
// Request FIFO holding C/R pairs. Registered head, no write-to-read bypass:
// an entry pushed in one cycle is visible at the head from the next cycle.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   push, push_const/reg : write an entry (caller guarantees not full)
//   pop                  : drop the head entry (caller guarantees not empty)
//   head_const/reg       : oldest entry (undefined when count == 0)
//   count                : occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module ldc_fifo
    import ldc_issue_pkg::*;
#(
    parameter int DATA_W = LDC_DATA_W,
    parameter int ADDR_W = LDC_ADDR_W,
    parameter int DEPTH  = LDC_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_const,
    input  logic [ADDR_W-1:0]          push_reg,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head_const,
    output logic [ADDR_W-1:0]          head_reg,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_const_q [DEPTH];
    logic [ADDR_W-1:0] mem_reg_q   [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is data only; stale contents are never visible because the
    // top gates the head with count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_const_q[wr_ptr_q] <= push_const;
            mem_reg_q[wr_ptr_q]   <= push_reg;
        end
    end

    assign head_const = mem_const_q[rd_ptr_q];
    assign head_reg   = mem_reg_q[rd_ptr_q];
    assign count      = count_q;

endmodule

// File: rtl/ldc_issue.sv
// ---------------------------------------------------------------------------
// ldc_issue
// Issues C/R pairs to the LDC stage, either from queued load-constant
// requests (IDLE) or as a bank fill that walks every register index with
// C = base + index (FILL).
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   bus         : ldc_issue_if.slave (request and LDC-stage handshakes)
//   fill_start  : pulse requesting a bank fill (only honoured when idle+empty)
//   fill_base   : fill seed, captured when the fill is accepted
//   busy        : FSM not idle or FIFO not empty
//   count       : FIFO occupancy
// ---------------------------------------------------------------------------
module ldc_issue
    import ldc_issue_pkg::*;
#(
    parameter int DATA_W = LDC_DATA_W,
    parameter int ADDR_W = LDC_ADDR_W,
    parameter int DEPTH  = LDC_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    ldc_issue_if.slave             bus,
    input  logic                   fill_start,
    input  logic [DATA_W-1:0]      fill_base,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count
);

    localparam int                CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    ldc_state_e        state_q, state_d;
    logic [ADDR_W-1:0] idx_q,   idx_d;
    logic [DATA_W-1:0] base_q,  base_d;

    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] head_const;
    logic [ADDR_W-1:0] head_reg;

    logic              req_ready;
    logic              push;
    logic              pop;
    logic              fill_go;
    logic              out_valid;
    logic [DATA_W-1:0] out_const;
    logic [ADDR_W-1:0] out_reg;

    ldc_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_const (bus.req_const),
        .push_reg   (bus.req_reg),
        .pop        (pop),
        .head_const (head_const),
        .head_reg   (head_reg),
        .count      (fifo_count)
    );

    always_comb begin
        // Ready never looks at out_ready: a full FIFO stays closed even while
        // the head is being consumed.
        req_ready = (state_q == IDLE) && (fifo_count < FULL_CNT);
        push      = bus.req_valid && req_ready;

        out_valid = 1'b0;
        out_const = '0;
        out_reg   = '0;
        if (state_q == FILL) begin
            out_valid = 1'b1;
            out_reg   = idx_q;
            out_const = base_q + DATA_W'(idx_q);
        end else if (fifo_count != '0) begin
            out_valid = 1'b1;
            out_reg   = head_reg;
            out_const = head_const;
        end

        pop = (state_q == IDLE) && out_valid && bus.out_ready;

        // A same-cycle push makes the FIFO non-empty, which blocks the fill.
        fill_go = (state_q == IDLE) && (fifo_count == '0) && fill_start && !push;

        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        case (state_q)
            IDLE: begin
                if (fill_go) begin
                    state_d = FILL;
                    idx_d   = '0;
                    base_d  = fill_base;
                end
            end
            FILL: begin
                if (bus.out_ready) begin
                    idx_d = idx_q + ADDR_W'(1);
                    if (idx_q == LAST_IDX) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_const = out_const;
    assign bus.out_reg   = out_reg;
    assign busy          = (state_q != IDLE) || (fifo_count != '0);
    assign count         = fifo_count;

endmodule
